lap_stopwatch: RTL and testbench
================================

Name: lap_stopwatch

Overview:
- Parametrised successor to the single-button stopwatch FSM: N-digit BCD stopwatch with start/stop, lap (split) capture and clear.
- Driven by two pre-synchronised push-button levels from upstream synckey instances.
- Owns its own tick prescaler.
- Feeds per-digit BCD to the ssdec display decoders in the FPGA top.

Parameters:
- NUM_DIGITS, 4: BCD digits in the count; time_o width is 4*NUM_DIGITS.
- TICK_DIV, 10: clk cycles per count increment (10 gives 0.1 s resolution at hz100); must be >= 1.
- LAP_W, 4: width of the lap counter.

Ports:
- clk  in  1  system clock (hz100 at top level).
- reset  in  1  synchronous, active-high reset.
- start_stop_i  in  1  synchronised button level; rising edge = press.
- lap_clear_i  in  1  synchronised button level; rising edge = press.
- mode_o  out  5  current state, stopwatch_pkg::sw_mode_t.
- time_o  out  4*NUM_DIGITS  displayed BCD time; digit 0 in [3:0].
- lap_cnt_o  out  LAP_W  number of laps captured since last clear.
- overflow_o  out  1  sticky; set when the count wraps.

Behaviour:
- Reset: state IDLE; count, lap register, prescaler, lap_cnt_o, overflow_o = 0; both edge-detect flops = 0.
- Edge detect: press = level & ~registered previous level. A held button produces exactly one press. Each decision uses presses sampled at a clock edge; the resulting state is visible on mode_o after that edge.
- States (one-hot): IDLE=00001, RUNNING=00010, STOPPED=00100, LAP=01000, CLEAR=10000.
- IDLE: start_stop press -> RUNNING, prescaler cleared. lap_clear press is ignored.
- RUNNING: start_stop press -> STOPPED. lap_clear press -> LAP; lap register <= live count; lap_cnt += 1.
- LAP: counting continues. lap_clear press -> RUNNING (display released). start_stop press -> STOPPED.
- STOPPED: start_stop press -> RUNNING; prescaler is not cleared, so partial ticks resume. lap_clear press -> CLEAR.
- CLEAR: lasts exactly 1 cycle, then IDLE unconditionally. Presses are ignored. Zeroes count, lap register, prescaler, lap_cnt, overflow.
- Simultaneous presses: start_stop takes priority; the lap_clear press is dropped.
- Prescaler: counts 0..TICK_DIV-1 only in RUNNING or LAP and holds otherwise. At TICK_DIV-1 it wraps to 0 and the count increments by 1 (BCD ripple); the new count is visible the next cycle.
- Leaving RUNNING/LAP via a start_stop press: the increment due on that same edge still occurs.
- BCD arithmetic: each digit rolls 9 -> 0 with carry into the next digit. If all digits are 9, the count wraps to 0 and overflow_o sets. overflow_o is cleared only by CLEAR or reset.
- time_o shows the lap register in LAP and the live count in every other state. All outputs are registered.
- lap_cnt wraps modulo 2^LAP_W.
- Reset mid-operation (any state) returns to the reset values on the next edge.

Optional Feature:
- Macro: LAP_STOPWATCH_SATURATE_EN.
- Defined: at all-9s the count holds at all-9s, overflow_o sets, and the prescaler keeps cycling with no further count change.
- Undefined: the count wraps as described in Behaviour.

Decomposition:
- stopwatch_pkg: sw_mode_t enum (5-bit one-hot values above), BCD_MAX digit constant 4'd9.
- Sub-module bcd_counter: parametrised by NUM_DIGITS. Ports: clk, reset, clear_i, inc_i, count_o, wrap_o. The saturate macro is honoured inside bcd_counter.
- FSM, edge detect, prescaler and lap register stay in lap_stopwatch.

Test Plan (NUM_DIGITS=2, TICK_DIV=2, LAP_W=4 unless noted):
- Reset, then one start_stop press -> mode_o=00010; after 20 cycles time_o=8'h10. Press again -> mode_o=00100; time_o holds 8'h10 for 10 more cycles.
- Run to time_o=8'h05, lap_clear press -> mode_o=01000, time_o frozen at 8'h05, lap_cnt_o=1. After 6 cycles, lap_clear press -> RUNNING with time_o=8'h08.
- From 8'h98 while running, 4 cycles -> time_o=8'h00, overflow_o=1. With LAP_STOPWATCH_SATURATE_EN: time_o=8'h99 held, overflow_o=1.
- In STOPPED, lap_clear press -> mode_o=10000 for exactly 1 cycle, then 00001; time_o, lap_cnt_o, overflow_o all 0.
- Both buttons rise on the same cycle in RUNNING -> STOPPED, lap_cnt_o unchanged. Holding start_stop high for 50 cycles yields exactly one transition.
- Assert reset for 1 cycle while in LAP with lap_cnt_o=3 -> next cycle mode_o=00001, all outputs 0.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types for the stopwatch family: one-hot mode encoding and BCD digit limit.
package stopwatch_pkg;

  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    RUNNING = 5'b00010,
    STOPPED = 5'b00100,
    LAP     = 5'b01000,
    CLEAR   = 5'b10000
  } sw_mode_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

endpackage

// File: rtl/bcd_counter.sv
// NUM_DIGITS-digit BCD up-counter with ripple carry; wrap_o flags an increment at all-9s.
// Define LAP_STOPWATCH_SATURATE_EN to hold at all-9s instead of wrapping to zero.
module bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic                    inc_i,
  output logic [4*NUM_DIGITS-1:0] count_o,
  output logic                    wrap_o
);

  logic [4*NUM_DIGITS-1:0] count_q;
  logic [4*NUM_DIGITS-1:0] count_d;
  logic                    carry;
  logic                    all_max;

  always_comb begin
    count_d = count_q;
    carry   = inc_i;
    all_max = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (count_q[4*i +: 4] != BCD_MAX) all_max = 1'b0;
      if (carry) begin
        if (count_q[4*i +: 4] == BCD_MAX) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry             = 1'b0;
        end
      end
    end
`ifdef LAP_STOPWATCH_SATURATE_EN
    if (all_max) count_d = count_q;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset || clear_i) count_q <= '0;
    else                  count_q <= count_d;
  end

  assign count_o = count_q;
  assign wrap_o  = inc_i & all_max;

endmodule

// File: rtl/lap_stopwatch.sv
// BCD stopwatch with start/stop, lap capture and clear, driven by two synchronised buttons.
// Build option LAP_STOPWATCH_SATURATE_EN (honoured in bcd_counter) saturates the count at all-9s.
module lap_stopwatch
  import stopwatch_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int TICK_DIV   = 10,
  parameter int LAP_W      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start_stop_i,
  input  logic                    lap_clear_i,
  output sw_mode_t                mode_o,
  output logic [4*NUM_DIGITS-1:0] time_o,
  output logic [LAP_W-1:0]        lap_cnt_o,
  output logic                    overflow_o
);

  localparam int CW = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  sw_mode_t          state_q, state_d;
  logic              ss_q, lc_q;
  logic              ss_press, lc_press;
  logic [PW-1:0]     presc_q;
  logic              counting, tick;
  logic              lap_capture, presc_clr, clear_act;
  logic [CW-1:0]     count;
  logic [CW-1:0]     lap_q;
  logic [LAP_W-1:0]  lap_cnt_q;
  logic              ovf_q;
  logic              wrap;

  assign ss_press = start_stop_i & ~ss_q;
  assign lc_press = lap_clear_i & ~lc_q;
  assign counting = (state_q == RUNNING) || (state_q == LAP);
  assign tick     = counting && (presc_q == PMAX);

  // start_stop is tested first everywhere, so a simultaneous lap_clear press is dropped
  always_comb begin
    state_d     = state_q;
    lap_capture = 1'b0;
    presc_clr   = 1'b0;
    clear_act   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_press) begin
          state_d   = RUNNING;
          presc_clr = 1'b1;
        end
      end
      RUNNING: begin
        if (ss_press) begin
          state_d = STOPPED;
        end else if (lc_press) begin
          state_d     = LAP;
          lap_capture = 1'b1;
        end
      end
      LAP: begin
        if (ss_press)      state_d = STOPPED;
        else if (lc_press) state_d = RUNNING;
      end
      STOPPED: begin
        if (ss_press) begin
          state_d = RUNNING;
        end else if (lc_press) begin
          state_d   = CLEAR;
          clear_act = 1'b1;
        end
      end
      CLEAR: begin
        state_d   = IDLE;
        clear_act = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      ss_q      <= 1'b0;
      lc_q      <= 1'b0;
      presc_q   <= '0;
      lap_q     <= '0;
      lap_cnt_q <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      ss_q    <= start_stop_i;
      lc_q    <= lap_clear_i;
      if (clear_act || presc_clr) presc_q <= '0;
      else if (tick)              presc_q <= '0;
      else if (counting)          presc_q <= presc_q + 1'b1;
      if (clear_act)        lap_q <= '0;
      else if (lap_capture) lap_q <= count;
      if (clear_act)        lap_cnt_q <= '0;
      else if (lap_capture) lap_cnt_q <= lap_cnt_q + 1'b1;
      if (clear_act)  ovf_q <= 1'b0;
      else if (wrap)  ovf_q <= 1'b1;
    end
  end

  bcd_counter #(
    .NUM_DIGITS (NUM_DIGITS)
  ) u_count (
    .clk     (clk),
    .reset   (reset),
    .clear_i (clear_act),
    .inc_i   (tick),
    .count_o (count),
    .wrap_o  (wrap)
  );

  assign mode_o     = state_q;
  assign time_o     = (state_q == LAP) ? lap_q : count;
  assign lap_cnt_o  = lap_cnt_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Bench for lap_stopwatch (2 digits, tick every 2 clocks): vector table, corner sequences, random vs model.
module tb_lap_stopwatch;

  localparam int ND   = 2;
  localparam int TD   = 2;
  localparam int LW   = 4;
  localparam int MAXV = 99;

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_STOP = 2;
  localparam int S_LAP  = 3;
  localparam int S_CLR  = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic            ss;
  logic            lc;
  logic [4:0]      mode;
  logic [4*ND-1:0] tim;
  logic [LW-1:0]   lapc;
  logic            ovf;

  int vectors     = 0;
  int miscompares = 0;

  // behavioural reference: decimal integers, state index = one-hot bit position
  int m_st, m_cnt, m_lap, m_lapn, m_presc;
  bit m_ovf, m_ssprev, m_lcprev;

  typedef struct {
    bit         ss;
    bit         lc;
    int         n;
    bit         all;
    logic [4:0] mode;
    logic [7:0] t;
    logic [3:0] lapn;
    bit         ovf;
  } vec_t;

  vec_t tbl[20];

  always #5 clk = ~clk;

  lap_stopwatch #(
    .NUM_DIGITS (ND),
    .TICK_DIV   (TD),
    .LAP_W      (LW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start_stop_i (ss),
    .lap_clear_i  (lc),
    .mode_o       (mode),
    .time_o       (tim),
    .lap_cnt_o    (lapc),
    .overflow_o   (ovf)
  );

  function automatic vec_t mk(input bit s, input bit l, input int n, input bit all,
                              input logic [4:0] md, input logic [7:0] t,
                              input logic [3:0] ln, input bit o);
    vec_t v;
    v.ss = s; v.lc = l; v.n = n; v.all = all;
    v.mode = md; v.t = t; v.lapn = ln; v.ovf = o;
    return v;
  endfunction

  function automatic int to_bcd(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < ND; i++) begin
      r = r | ((x % 10) << (4 * i));
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_step(input bit r, input bit s, input bit l);
    bit sp, lp;
    int old;
    if (r) begin
      m_st = S_IDLE; m_cnt = 0; m_lap = 0; m_lapn = 0; m_presc = 0;
      m_ovf = 0; m_ssprev = 0; m_lcprev = 0;
      return;
    end
    sp = s && !m_ssprev;
    lp = l && !m_lcprev;
    m_ssprev = s;
    m_lcprev = l;
    old = m_cnt;
    if (m_st == S_RUN || m_st == S_LAP) begin
      m_presc = m_presc + 1;
      if (m_presc == TD) begin
        m_presc = 0;
        if (m_cnt == MAXV) begin
          m_ovf = 1;
`ifdef LAP_STOPWATCH_SATURATE_EN
          m_cnt = MAXV;
`else
          m_cnt = 0;
`endif
        end else begin
          m_cnt = m_cnt + 1;
        end
      end
    end
    case (m_st)
      S_IDLE: if (sp) begin m_st = S_RUN; m_presc = 0; end
      S_RUN: begin
        if (sp) m_st = S_STOP;
        else if (lp) begin
          m_st = S_LAP; m_lap = old; m_lapn = (m_lapn + 1) % (1 << LW);
        end
      end
      S_LAP: begin
        if (sp) m_st = S_STOP;
        else if (lp) m_st = S_RUN;
      end
      S_STOP: begin
        if (sp) m_st = S_RUN;
        else if (lp) begin
          m_st = S_CLR; m_cnt = 0; m_lap = 0; m_lapn = 0; m_presc = 0; m_ovf = 0;
        end
      end
      default: m_st = S_IDLE;
    endcase
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_model(input string tag);
    chk({tag, " mode"}, int'(mode), 1 << m_st);
    chk({tag, " time"}, int'(tim), to_bcd((m_st == S_LAP) ? m_lap : m_cnt));
    chk({tag, " lap_cnt"}, int'(lapc), m_lapn);
    chk({tag, " overflow"}, int'(ovf), int'(m_ovf));
  endtask

  task automatic cyc(input bit r, input bit s, input bit l);
    reset = r; ss = s; lc = l;
    model_step(r, s, l);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int mode_changes;
    logic [4:0] last_mode;
    bit rs, rl;

    tbl[0]  = mk(0, 0, 1,  1, 5'b00001, 8'h00, 4'd0, 0);
    tbl[1]  = mk(1, 0, 1,  1, 5'b00010, 8'h00, 4'd0, 0);
    tbl[2]  = mk(0, 0, 20, 1, 5'b00010, 8'h10, 4'd0, 0);
    tbl[3]  = mk(1, 0, 1,  1, 5'b00100, 8'h10, 4'd0, 0);
    tbl[4]  = mk(0, 0, 10, 1, 5'b00100, 8'h10, 4'd0, 0);
    tbl[5]  = mk(1, 0, 1,  1, 5'b00010, 8'h10, 4'd0, 0);
    tbl[6]  = mk(0, 0, 1,  1, 5'b00010, 8'h11, 4'd0, 0);
    tbl[7]  = mk(0, 0, 1,  1, 5'b00010, 8'h11, 4'd0, 0);
    tbl[8]  = mk(0, 1, 1,  1, 5'b01000, 8'h11, 4'd1, 0);
    tbl[9]  = mk(0, 1, 5,  1, 5'b01000, 8'h11, 4'd1, 0);
    tbl[10] = mk(0, 0, 1,  1, 5'b01000, 8'h11, 4'd1, 0);
    tbl[11] = mk(0, 1, 1,  1, 5'b00010, 8'h15, 4'd1, 0);
    tbl[12] = mk(0, 0, 1,  1, 5'b00010, 8'h16, 4'd1, 0);
    tbl[13] = mk(0, 0, 1,  1, 5'b00010, 8'h16, 4'd1, 0);
    tbl[14] = mk(1, 1, 1,  1, 5'b00100, 8'h17, 4'd1, 0);
    tbl[15] = mk(1, 0, 50, 1, 5'b00100, 8'h17, 4'd1, 0);
    tbl[16] = mk(0, 1, 1,  0, 5'b10000, 8'h00, 4'd0, 0);
    tbl[17] = mk(0, 1, 1,  1, 5'b00001, 8'h00, 4'd0, 0);
    tbl[18] = mk(0, 0, 1,  1, 5'b00001, 8'h00, 4'd0, 0);
    tbl[19] = mk(0, 1, 1,  1, 5'b00001, 8'h00, 4'd0, 0);

    reset = 1'b1; ss = 1'b0; lc = 1'b0;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    chk("reset mode", int'(mode), 5'b00001);
    chk("reset time", int'(tim), 0);
    chk("reset lap_cnt", int'(lapc), 0);
    chk("reset overflow", int'(ovf), 0);

    for (int i = 0; i < 20; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(0, tbl[i].ss, tbl[i].lc);
      chk($sformatf("row%0d mode", i), int'(mode), int'(tbl[i].mode));
      if (tbl[i].all) begin
        chk($sformatf("row%0d time", i), int'(tim), int'(tbl[i].t));
        chk($sformatf("row%0d lap_cnt", i), int'(lapc), int'(tbl[i].lapn));
        chk($sformatf("row%0d overflow", i), int'(ovf), int'(tbl[i].ovf));
      end
    end

    // count through 98 -> 99 -> wrap (or saturate), then clear the sticky flag
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    repeat (196) cyc(0, 0, 0);
    chk("ovf pre time", int'(tim), 8'h98);
    chk("ovf pre flag", int'(ovf), 0);
    repeat (4) cyc(0, 0, 0);
`ifdef LAP_STOPWATCH_SATURATE_EN
    chk("ovf time", int'(tim), 8'h99);
`else
    chk("ovf time", int'(tim), 8'h00);
`endif
    chk("ovf flag", int'(ovf), 1);
    repeat (4) cyc(0, 0, 0);
    chk_model("ovf after");
    cyc(0, 1, 0);
    cyc(0, 0, 1);
    chk("clear mode", int'(mode), 5'b10000);
    cyc(0, 0, 0);
    chk("clear idle mode", int'(mode), 5'b00001);
    chk("clear time", int'(tim), 0);
    chk("clear flag", int'(ovf), 0);

    // three laps, then reset while in LAP
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1);
      cyc(0, 0, 0);
    end
    chk("lap3 mode", int'(mode), 5'b01000);
    chk("lap3 count", int'(lapc), 3);
    cyc(1, 0, 0);
    chk("lapreset mode", int'(mode), 5'b00001);
    chk("lapreset time", int'(tim), 0);
    chk("lapreset lap_cnt", int'(lapc), 0);
    chk("lapreset overflow", int'(ovf), 0);

    // held start_stop gives exactly one transition
    mode_changes = 0;
    last_mode = mode;
    repeat (50) begin
      cyc(0, 1, 0);
      if (mode != last_mode) mode_changes++;
      last_mode = mode;
    end
    chk("held press transitions", mode_changes, 1);
    chk("held press mode", int'(mode), 5'b00010);

    // randomized levels against the reference model
    rs = 0; rl = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rs = ~rs;
      if ($urandom_range(0, 4) == 0) rl = ~rl;
      cyc(($urandom_range(0, 399) == 0), rs, rl);
      chk_model($sformatf("rand%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
